uart_rx_param: RTL and testbench

Parametrised UART receiver, next generation of the fixed 8N1 receiver block. Configurable bit period, data width, parity mode and stop-bit count. Adds an input synchroniser, parity and framing error detection, and a valid/ready output handshake with overrun reporting. Sits between the board RX pin and the byte-stream consumer (command parser / RX FIFO).

---
 rtl/uart_rx_param.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, parity/framing checks, valid/ready output with overrun.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority around every sample point.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  // With majority voting every sample fires one cycle later, once the t+1 value is available.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_CNT = HALF;
`else
  localparam int START_CNT = HALF - 1;
`endif
  localparam logic [CW-1:0] START_LAST = CW'(START_CNT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, prev_q, sample_bit, tick;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic                   deliver_q, deliver_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic prev2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev2_q <= 1'b1;
    else        prev2_q <= prev_q;
  end
  assign sample_bit = (rx_s & prev_q) | (rx_s & prev2_q) | (prev_q & prev2_q);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      prev_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      deliver_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q    <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      deliver_q <= deliver_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    deliver_d = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    ov_d      = 1'b0;
    tick      = (cnt_q == ((state_q == S_START) ? START_LAST : BIT_LAST));

    // The counter restarts at every sample point, so it never exceeds one bit period.
    if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) state_d = sample_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          perr_d  = (PARITY == 1) ? ~(^shift_q ^ sample_bit) : (^shift_q ^ sample_bit);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!sample_bit) ferr_d = 1'b1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d     = '0;
            state_d   = S_IDLE;
            deliver_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completed word wins over a plain handshake; an unconsumed old word forces a drop.
    if (deliver_q) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        pe_d    = perr_q;
        fe_d    = ferr_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three receiver configurations (8N1, 7E1, 8N2) fed from a
// vector table plus hand-written glitch, break, overrun and mid-frame reset sequences.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } word_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       parBit;
    logic       stop1;
    logic       stop2;
    logic [8:0] expData;
    logic       expPe;
    logic       expFe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxLine;
  logic [2:0] rxReady;

  logic [7:0] dataA, dataC;
  logic [6:0] dataB;
  logic       validA, peA, feA, ovA, busyA;
  logic       validB, peB, feB, ovB, busyB;
  logic       validC, peC, feC, ovC, busyC;

  word_t expQ0[$], expQ1[$], expQ2[$];
  int    assertCount = 0;
  int    failCount   = 0;
  int    ovCount[3]  = '{0, 0, 0};
  vec_t  vecs[9];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dutA (
    .clk(clk), .rst_n(rst_n), .rx(rxLine[0]), .rx_data(dataA), .rx_valid(validA),
    .rx_ready(rxReady[0]), .parity_err(peA), .frame_err(feA), .overrun(ovA), .busy(busyA));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dutB (
    .clk(clk), .rst_n(rst_n), .rx(rxLine[1]), .rx_data(dataB), .rx_valid(validB),
    .rx_ready(rxReady[1]), .parity_err(peB), .frame_err(feB), .overrun(ovB), .busy(busyB));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(3)) dutC (
    .clk(clk), .rst_n(rst_n), .rx(rxLine[2]), .rx_data(dataC), .rx_valid(validC),
    .rx_ready(rxReady[2]), .parity_err(peC), .frame_err(feC), .overrun(ovC), .busy(busyC));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkWord(input int sel, input logic [8:0] d, input logic pe, input logic fe);
    word_t w;
    int    n;
    n = (sel == 0) ? expQ0.size() : (sel == 1) ? expQ1.size() : expQ2.size();
    if (n == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL unexpectedWord dut%0d: got 0x%0h, expected no word", sel, d);
    end else begin
      case (sel)
        0:       w = expQ0.pop_front();
        1:       w = expQ1.pop_front();
        default: w = expQ2.pop_front();
      endcase
      checkOutput($sformatf("dut%0d.rx_data", sel), {23'd0, d}, {23'd0, w.data});
      checkOutput($sformatf("dut%0d.parity_err", sel), {31'd0, pe}, {31'd0, w.pe});
      checkOutput($sformatf("dut%0d.frame_err", sel), {31'd0, fe}, {31'd0, w.fe});
    end
  endtask

  // Consumption monitor: every accepted word must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (validA && rxReady[0]) checkWord(0, {1'b0, dataA}, peA, feA);
      if (validB && rxReady[1]) checkWord(1, {2'b0, dataB}, peB, feB);
      if (validC && rxReady[2]) checkWord(2, {1'b0, dataC}, peC, feC);
      if (ovA) ovCount[0]++;
      if (ovB) ovCount[1]++;
      if (ovC) ovCount[2]++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input int sel, input logic b);
    rxLine[sel] = b;
    waitCycles(CPB);
  endtask

  // Drives one frame shaped for the selected receiver, then leaves the line at idleLevel.
  task automatic applyStimulus(input int sel, input logic [8:0] data, input logic parBit,
                               input logic stop1, input logic stop2, input logic idleLevel);
    int nData;
    nData = (sel == 1) ? 7 : 8;
    sendBit(sel, 1'b0);
    for (int i = 0; i < nData; i++) sendBit(sel, data[i]);
    if (sel == 1) sendBit(sel, parBit);
    sendBit(sel, stop1);
    if (sel == 2) sendBit(sel, stop2);
    rxLine[sel] = idleLevel;
  endtask

  task automatic pushExp(input int sel, input logic [8:0] d, input logic pe, input logic fe);
    word_t w;
    w.data = d;
    w.pe   = pe;
    w.fe   = fe;
    case (sel)
      0:       expQ0.push_back(w);
      1:       expQ1.push_back(w);
      default: expQ2.push_back(w);
    endcase
  endtask

  function automatic logic busyOf(input int sel);
    case (sel)
      0:       return busyA;
      1:       return busyB;
      default: return busyC;
    endcase
  endfunction

  initial begin
    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h003, 1'b1, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h003, 1'b0, 1'b1, 1'b1, 9'h003, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h07F, 1'b1, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0};
    vecs[6] = '{2, 9'h0C3, 1'b0, 1'b1, 1'b1, 9'h0C3, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h081, 1'b0, 1'b1, 1'b0, 9'h081, 1'b0, 1'b1};
    vecs[8] = '{0, 9'h096, 1'b0, 1'b0, 1'b1, 9'h096, 1'b0, 1'b1};

    rst_n   = 1'b0;
    rxLine  = 3'b111;
    rxReady = 3'b111;
    waitCycles(3);
    checkOutput("reset.rx_data", {24'd0, dataA}, 32'd0);
    checkOutput("reset.rx_valid", {31'd0, validA}, 32'd0);
    checkOutput("reset.parity_err", {31'd0, peA}, 32'd0);
    checkOutput("reset.frame_err", {31'd0, feA}, 32'd0);
    checkOutput("reset.overrun", {31'd0, ovA}, 32'd0);
    checkOutput("reset.busy", {29'd0, busyA, busyB, busyC}, 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    for (int i = 0; i < 9; i++) begin
      pushExp(vecs[i].sel, vecs[i].expData, vecs[i].expPe, vecs[i].expFe);
      applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].parBit, vecs[i].stop1, vecs[i].stop2, 1'b1);
      waitCycles(24);
      checkOutput($sformatf("vec%0d.busyIdle", i), {31'd0, busyOf(vecs[i].sel)}, 32'd0);
    end

    // Short low pulse on the line must be rejected by the start-bit check.
    rxLine[0] = 1'b0;
    waitCycles(5);
    checkOutput("glitch.busyHigh", {31'd0, busyA}, 32'd1);
    rxLine[0] = 1'b1;
    waitCycles(12);
    checkOutput("glitch.busyLow", {31'd0, busyA}, 32'd0);
    checkOutput("glitch.noValid", {31'd0, validA}, 32'd0);

    // Break: bad stop bit with the line left low, then a clean frame after release.
    pushExp(0, 9'h03C, 1'b0, 1'b1);
    applyStimulus(0, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(3 * CPB);
    checkOutput("break.busyWhileLow", {31'd0, busyA}, 32'd0);
    rxLine[0] = 1'b1;
    waitCycles(CPB);
    pushExp(0, 9'h055, 1'b0, 1'b0);
    applyStimulus(0, 9'h055, 1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(24);
    checkOutput("break.queueEmpty", expQ0.size(), 32'd0);

    // Overrun: second word arrives while the first is still unconsumed.
    rxReady[0] = 1'b0;
    applyStimulus(0, 9'h011, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 9'h022, 1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(24);
    checkOutput("overrun.validHeld", {31'd0, validA}, 32'd1);
    checkOutput("overrun.dataKept", {24'd0, dataA}, 32'h11);
    checkOutput("overrun.pulseCount", ovCount[0], 32'd1);
    pushExp(0, 9'h011, 1'b0, 1'b0);
    rxReady[0] = 1'b1;
    waitCycles(1);
    checkOutput("overrun.validDrop", {31'd0, validA}, 32'd0);
    waitCycles(4);

    // Reset in the middle of data bit 3 on the two-stop-bit receiver.
    rxLine[2] = 1'b0;
    waitCycles(CPB);
    sendBit(2, 1'b0);
    sendBit(2, 1'b1);
    sendBit(2, 1'b0);
    rxLine[2] = 1'b1;
    waitCycles(CPB / 2);
    checkOutput("midReset.busyBefore", {31'd0, busyC}, 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("midReset.rx_data", {24'd0, dataC}, 32'd0);
    checkOutput("midReset.flags", {27'd0, validC, peC, feC, ovC, busyC}, 32'd0);
    checkOutput("midReset.dutA_data", {24'd0, dataA}, 32'd0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2 * CPB);
    checkOutput("midReset.noPartial", {31'd0, validC}, 32'd0);
    pushExp(2, 9'h05A, 1'b0, 1'b0);
    applyStimulus(2, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b1);
    waitCycles(24);

    checkOutput("final.queueA", expQ0.size(), 32'd0);
    checkOutput("final.queueB", expQ1.size(), 32'd0);
    checkOutput("final.queueC", expQ2.size(), 32'd0);
    checkOutput("final.overrunB", ovCount[1], 32'd0);
    checkOutput("final.overrunC", ovCount[2], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
